mem_access_unit: RTL and testbench

- Parametrised load/store sequencer that replaces ad-hoc MAR/MDR/RAM strobing in the SPARC V8 datapath.
- Accepts one memory request from the control unit and checks alignment.
- Drives the RAM handshake (enable/opcode/address, waits for MFC).
- Performs big-endian lane steering with sign/zero extension, and sequences doubleword (LDD/STD) accesses as two word transfers.
- Raises a SPARC trap request on misalignment (and, optionally, on MFC timeout).

---
 rtl/sparc_mem_pkg.sv | 45 ++++
 rtl/mem_lane_steer.sv | 71 +++++++
 rtl/mem_access_unit.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC V8 memory access unit.
// Holds access-size encodings, trap types, FSM state encoding, the latched
// request control payload and the alignment helper.
package sparc_mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE   = 2'b00,
      SZ_HALF   = 2'b01,
      SZ_WORD   = 2'b10,
      SZ_DOUBLE = 2'b11
   } size_t;

   localparam logic [7:0] TT_MEM_NOT_ALIGNED = 8'h07;
   localparam logic [7:0] TT_DATA_ACCESS_EXC = 8'h09;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACC1,
      ST_ACC2,
      ST_DONE,
      ST_TRAP
   } state_t;

   // Control fields of an accepted request, held for the whole access
   typedef struct packed {
      logic  is_store;
      size_t size;
      logic  sign_ext;
   } req_ctl_t;

   // Natural alignment check; a word is the full bus width, a double is two words
   function automatic logic misaligned(size_t sz, logic [7:0] low, int unsigned bytes);
      logic [7:0] mask;
      mask = 8'h00;
      case (sz)
         SZ_BYTE:   mask = 8'h00;
         SZ_HALF:   mask = 8'h01;
         SZ_WORD:   mask = 8'(bytes - 1);
         SZ_DOUBLE: mask = 8'(2 * bytes - 1);
         default:   mask = 8'h00;
      endcase
      return |(low & mask);
   endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Big-endian lane steering for the memory access unit (combinational).
// Ports:
//   size, sign_ext, offset : access size, load extension mode, byte offset in word
//   rdata                  : raw RAM read word
//   wdata                  : store datum (right-justified)
//   load_data_c            : extracted, right-justified, extended load value
//   store_data_c           : store datum replicated into every candidate lane
//   be_c                   : byte enables, MSB lane = lowest byte address
module mem_lane_steer
   import sparc_mem_pkg::*;
#(
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned BYTES  = DATA_W / 8,
   localparam int unsigned OFF_W  = $clog2(BYTES)
) (
   input  size_t             size,
   input  logic              sign_ext,
   input  logic [OFF_W-1:0]  offset,
   input  logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] load_data_c,
   output logic [DATA_W-1:0] store_data_c,
   output logic [BYTES-1:0]  be_c
);

   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic [BYTES-1:0] byte_be;
   logic [BYTES-1:0] half_be;

   // Lane select: byte at offset o sits in lane BYTES-1-o
   always_comb begin
      byte_v  = '0;
      half_v  = '0;
      byte_be = '0;
      half_be = '0;
      for (int i = 0; i < int'(BYTES); i++) begin
         if (OFF_W'(BYTES - 1 - i) == offset) begin
            byte_v     = rdata[i*8 +: 8];
            byte_be[i] = 1'b1;
         end
      end
      for (int i = 0; i < int'(BYTES / 2); i++) begin
         if (OFF_W'(BYTES - 2 - 2 * i) == offset) begin
            half_v           = rdata[i*16 +: 16];
            half_be[i*2 +: 2] = 2'b11;
         end
      end
   end

   // Extend loads, replicate stores; word and double pass through untouched
   always_comb begin
      load_data_c  = rdata;
      store_data_c = wdata;
      be_c         = '1;
      case (size)
         SZ_BYTE: begin
            load_data_c  = {{(DATA_W - 8){sign_ext & byte_v[7]}}, byte_v};
            store_data_c = {BYTES{wdata[7:0]}};
            be_c         = byte_be;
         end
         SZ_HALF: begin
            load_data_c  = {{(DATA_W - 16){sign_ext & half_v[15]}}, half_v};
            store_data_c = {(BYTES / 2){wdata[15:0]}};
            be_c         = half_be;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer for the SPARC V8 datapath.
// Accepts one request in IDLE, checks alignment, runs one (or two for
// doubleword) RAM handshakes waiting on MFC, steers lanes, then pulses done;
// misaligned requests pulse trap instead without touching memory.
// Optional macro MEM_TIMEOUT_EN: trap with data_access_exception when MFC has
// not arrived within TIMEOUT_CYC cycles of an access starting.
// Ports:
//   Clk, Clr                  : clock, synchronous active-high reset
//   start, is_store, size,
//   sign_ext, addr, wdata,
//   wdata2                    : request from the control unit
//   mem_en, mem_we, mem_addr,
//   mem_be, mem_wdata         : RAM command (registered)
//   mem_rdata, mem_mfc        : RAM response
//   busy, done, rdata, rdata2 : status and load results
//   trap, tt                  : trap request and trap type
module mem_access_unit
   import sparc_mem_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic                Clk,
   input  logic                Clr,
   input  logic                start,
   input  logic                is_store,
   input  logic [1:0]          size,
   input  logic                sign_ext,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W-1:0]   wdata2,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_mfc,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   rdata,
   output logic [DATA_W-1:0]   rdata2,
   output logic                trap,
   output logic [7:0]          tt
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

`ifdef MEM_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   state_t              state, state_nxt;
   req_ctl_t            ctl_q, ctl_nxt;
   logic [ADDR_W-1:0]   addr_q, addr_nxt;
   logic [DATA_W-1:0]   wdata_q, wdata_nxt;
   logic [DATA_W-1:0]   wdata2_q, wdata2_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                tmo_hit;
   logic                cap1, cap2;
   logic [7:0]          tt_nxt;

   logic                mem_en_nxt, mem_we_nxt;
   logic [ADDR_W-1:0]   mem_addr_nxt, base_addr;
   logic [BYTES-1:0]    mem_be_nxt;
   logic [DATA_W-1:0]   mem_wdata_nxt;

   logic [DATA_W-1:0]   load_data_c, store_data_c;
   logic [BYTES-1:0]    be_c;

   // Steering sees the request that will be held next cycle, so the command
   // registers are loaded with the right lanes on the IDLE->ACC1 edge
   mem_lane_steer #(.DATA_W(DATA_W)) u_steer (
      .size         (ctl_nxt.size),
      .sign_ext     (ctl_nxt.sign_ext),
      .offset       (addr_nxt[OFF_W-1:0]),
      .rdata        (mem_rdata),
      .wdata        (wdata_nxt),
      .load_data_c  (load_data_c),
      .store_data_c (store_data_c),
      .be_c         (be_c)
   );

   assign tmo_hit = TMO_EN && (cnt == CNT_W'(TIMEOUT_CYC - 1));

   // Next-state, request latch and wait counter
   always_comb begin
      state_nxt  = state;
      ctl_nxt    = ctl_q;
      addr_nxt   = addr_q;
      wdata_nxt  = wdata_q;
      wdata2_nxt = wdata2_q;
      cnt_nxt    = '0;
      cap1       = 1'b0;
      cap2       = 1'b0;
      tt_nxt     = '0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (misaligned(size_t'(size), 8'(addr), BYTES)) begin
                  state_nxt = ST_TRAP;
                  tt_nxt    = TT_MEM_NOT_ALIGNED;
               end else begin
                  state_nxt        = ST_ACC1;
                  ctl_nxt.is_store = is_store;
                  ctl_nxt.size     = size_t'(size);
                  ctl_nxt.sign_ext = sign_ext;
                  addr_nxt         = addr;
                  wdata_nxt        = wdata;
                  wdata2_nxt       = wdata2;
               end
            end
         end
         ST_ACC1, ST_ACC2: begin
            if (mem_mfc) begin
               cap1      = (state == ST_ACC1) && !ctl_q.is_store;
               cap2      = (state == ST_ACC2) && !ctl_q.is_store;
               state_nxt = (state == ST_ACC1 && ctl_q.size == SZ_DOUBLE) ? ST_ACC2 : ST_DONE;
            end else if (tmo_hit) begin
               state_nxt = ST_TRAP;
               tt_nxt    = TT_DATA_ACCESS_EXC;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_DONE, ST_TRAP: state_nxt = ST_IDLE;
         default:          state_nxt = ST_IDLE;
      endcase
   end

   // Registered-output decode from the upcoming state
   always_comb begin
      base_addr     = addr_nxt & ~ADDR_W'(BYTES - 1);
      mem_en_nxt    = (state_nxt == ST_ACC1) || (state_nxt == ST_ACC2);
      mem_we_nxt    = mem_en_nxt & ctl_nxt.is_store;
      mem_addr_nxt  = '0;
      mem_be_nxt    = '0;
      mem_wdata_nxt = '0;
      if (state_nxt == ST_ACC1) begin
         mem_addr_nxt = base_addr;
         mem_be_nxt   = be_c;
         if (ctl_nxt.is_store) mem_wdata_nxt = store_data_c;
      end else if (state_nxt == ST_ACC2) begin
         mem_addr_nxt = base_addr + ADDR_W'(BYTES);
         mem_be_nxt   = '1;
         if (ctl_nxt.is_store) mem_wdata_nxt = wdata2_nxt;
      end
   end

   // State, request and output registers; Clr aborts any access in flight
   always_ff @(posedge Clk) begin
      if (Clr) begin
         state     <= ST_IDLE;
         ctl_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wdata2_q  <= '0;
         cnt       <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         trap      <= 1'b0;
         tt        <= '0;
         rdata     <= '0;
         rdata2    <= '0;
      end else begin
         state     <= state_nxt;
         ctl_q     <= ctl_nxt;
         addr_q    <= addr_nxt;
         wdata_q   <= wdata_nxt;
         wdata2_q  <= wdata2_nxt;
         cnt       <= cnt_nxt;
         mem_en    <= mem_en_nxt;
         mem_we    <= mem_we_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_be    <= mem_be_nxt;
         mem_wdata <= mem_wdata_nxt;
         busy      <= state_nxt != ST_IDLE;
         done      <= state_nxt == ST_DONE;
         trap      <= state_nxt == ST_TRAP;
         tt        <= tt_nxt;
         if (cap1) rdata  <= load_data_c;
         if (cap2) rdata2 <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (DATA_W=32, ADDR_W=8).
// A RAM responder answers with programmable MFC delay; a byte-level shadow
// memory predicts load results and completion latency; a scoreboard queue
// holds expectations until done/trap appears.
module tb_mem_access_unit;
   import sparc_mem_pkg::*;

   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 8;
   localparam int unsigned TMO = 15;

   logic          Clk = 1'b0;
   logic          Clr;
   logic          start, is_store, sign_ext;
   logic [1:0]    size;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata, wdata2;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_mfc;
   logic          busy, done, trap;
   logic [DW-1:0] rdata, rdata2;
   logic [7:0]    tt;

   mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
      .Clk(Clk), .Clr(Clr), .start(start), .is_store(is_store), .size(size),
      .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .wdata2(wdata2),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_mfc(mem_mfc),
      .busy(busy), .done(done), .rdata(rdata), .rdata2(rdata2),
      .trap(trap), .tt(tt)
   );

   always #5 Clk = ~Clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- RAM responder ----------------
   logic [31:0] mem_w [64];
   logic [7:0]  ref_b [256];
   bit          mem_init_done = 0;
   bit          mfc_block = 0;
   int          mfc_delay = 0;
   int          wait_cnt  = 0;
   int          en_cycles = 0;
   logic [7:0]  log_addr [$];
   logic        last_we;
   logic [3:0]  last_be;
   logic [31:0] last_wd;

   function automatic logic [31:0] init_word(input int k);
      if (k == 1) return 32'h12F4_5678;
      return {8'(k * 4) ^ 8'hA5, 8'(k * 4 + 1) ^ 8'h5A, 8'(k * 4 + 2) ^ 8'h3C, 8'(k * 4 + 3) ^ 8'hC3};
   endfunction

   always @(negedge Clk) begin
      if (!mem_init_done) begin
         for (int k = 0; k < 64; k++) mem_w[k] = init_word(k);
         mem_init_done = 1;
      end
      if (mem_en) begin
         en_cycles++;
         if (!mfc_block && wait_cnt >= mfc_delay) begin
            mem_mfc   = 1'b1;
            mem_rdata = mem_w[mem_addr[7:2]];
            wait_cnt  = 0;
            log_addr.push_back(mem_addr);
            last_we = mem_we;
            last_be = mem_be;
            last_wd = mem_wdata;
            if (mem_we)
               for (int i = 0; i < 4; i++)
                  if (mem_be[i]) mem_w[mem_addr[7:2]][i*8 +: 8] = mem_wdata[i*8 +: 8];
         end else begin
            mem_mfc   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            wait_cnt++;
         end
      end else begin
         mem_mfc   = 1'b0;
         mem_rdata = 32'hDEAD_BEEF;
         wait_cnt  = 0;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit          is_trap;
      logic [7:0]  tt;
      logic [31:0] rd;
      logic [31:0] rd2;
      int          start;
      int          lat;
   } exp_t;

   exp_t        sb [$];
   exp_t        mon_e;
   logic [31:0] trk_rd  = '0;
   logic [31:0] trk_rd2 = '0;

   always @(negedge Clk) begin
      if (!Clr && (done || trap)) begin
         if (sb.size() == 0) begin
            check("unexpected_completion", {30'b0, done, trap}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check("trap_flag", {31'b0, trap}, {31'b0, mon_e.is_trap});
            check("done_flag", {31'b0, done}, {31'b0, !mon_e.is_trap});
            if (mon_e.is_trap) check("tt", {24'b0, tt}, {24'b0, mon_e.tt});
            check("rdata", rdata, mon_e.rd);
            check("rdata2", rdata2, mon_e.rd2);
            check("latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
         end
      end
   end

   // Drive one request, predict its outcome, wait for it to complete
   task automatic issue(input bit st, input logic [1:0] sz, input bit sx, input logic [7:0] a,
                        input logic [31:0] wd, input logic [31:0] wd2, input int d, input bit tmo);
      exp_t        e;
      int          nb;
      logic [63:0] v;
      logic [7:0]  b;
      bit          mis;
      mfc_delay = d;
      mfc_block = tmo;
      @(posedge Clk); #1;
      mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (sz == 2'd3 && a[2:0] != 3'd0);
      nb  = 1 << sz;
      e.start   = cyc;
      e.is_trap = 0;
      e.tt      = '0;
      if (mis) begin
         e.is_trap = 1; e.tt = 8'h07; e.lat = 1;
      end else if (tmo) begin
         e.is_trap = 1; e.tt = 8'h09; e.lat = TMO + 1;
      end else begin
         e.lat = (sz == 2'd3) ? 3 + 2 * d : 2 + d;
         if (st) begin
            for (int j = 0; j < nb; j++) begin
               if (sz == 2'd3) b = (j < 4) ? wd[8*(3-j) +: 8] : wd2[8*(7-j) +: 8];
               else            b = wd[8*(nb-1-j) +: 8];
               ref_b[8'(a + j)] = b;
            end
         end else begin
            v = '0;
            for (int j = 0; j < nb; j++) v = {v[55:0], ref_b[8'(a + j)]};
            case (sz)
               2'd0: trk_rd = {{24{sx & v[7]}}, v[7:0]};
               2'd1: trk_rd = {{16{sx & v[15]}}, v[15:0]};
               2'd2: trk_rd = v[31:0];
               default: begin trk_rd = v[63:32]; trk_rd2 = v[31:0]; end
            endcase
         end
      end
      e.rd  = trk_rd;
      e.rd2 = trk_rd2;
      sb.push_back(e);
      start = 1; is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd; wdata2 = wd2;
      @(posedge Clk); #1;
      start = 0; is_store = ~st; size = ~sz; sign_ext = ~sx; addr = ~a; wdata = ~wd; wdata2 = ~wd2;
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge Clk);
      check("drain", sb.size(), 32'd0);
      mfc_block = 0;
   endtask

   int en_before;

   initial begin
      Clr = 1; start = 0; is_store = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0; wdata2 = 0;
      for (int k = 0; k < 64; k++)
         for (int j = 0; j < 4; j++) begin
            logic [31:0] w;
            w = init_word(k);
            ref_b[k * 4 + j] = w[31 - 8 * j -: 8];
         end

      // Reset state
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check("rst_mem_en", {31'b0, mem_en}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_trap", {31'b0, trap}, 32'd0);
      check("rst_tt", {24'b0, tt}, 32'd0);
      check("rst_mem_be", {28'b0, mem_be}, 32'd0);
      check("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_rdata2", rdata2, 32'd0);
      @(posedge Clk); #1 Clr = 0;

      // Signed byte load, MFC immediate
      issue(0, 2'd0, 1, 8'h05, 32'h0, 32'h0, 0, 0);
      check("lb_value", rdata, 32'hFFFF_FFF4);

      // Halfword store to the low lanes
      log_addr.delete();
      issue(1, 2'd1, 0, 8'h02, 32'h0000_BEEF, 32'h0, 0, 0);
      check("sh_we", {31'b0, last_we}, 32'd1);
      check("sh_be", {28'b0, last_be}, 32'b0011);
      check("sh_wdata", {16'b0, last_wd[15:0]}, 32'h0000_BEEF);
      check("sh_addr", {24'b0, log_addr[0]}, 32'h00);

      // Doubleword load with two wait cycles per word
      log_addr.delete();
      issue(0, 2'd3, 0, 8'h10, 32'h0, 32'h0, 2, 0);
      check("ldd_n_acc", log_addr.size(), 32'd2);
      check("ldd_addr0", {24'b0, log_addr[0]}, 32'h10);
      check("ldd_addr1", {24'b0, log_addr[1]}, 32'h14);

      // Misaligned word: trap, no memory cycle
      en_before = en_cycles;
      issue(0, 2'd2, 0, 8'h06, 32'h0, 32'h0, 0, 0);
      check("trap_no_en", 32'(en_cycles - en_before), 32'd0);

      // Clr in the middle of an access
      mfc_block = 1;
      @(posedge Clk); #1;
      start = 1; is_store = 0; size = 2'd2; addr = 8'h20;
      @(posedge Clk); #1 start = 0;
      @(negedge Clk);
      check("acc1_en", {31'b0, mem_en}, 32'd1);
      check("acc1_busy", {31'b0, busy}, 32'd1);
      @(posedge Clk); #1 Clr = 1;
      @(posedge Clk); #1 Clr = 0;
      @(negedge Clk);
      check("clr_mem_en", {31'b0, mem_en}, 32'd0);
      check("clr_busy", {31'b0, busy}, 32'd0);
      check("clr_done", {31'b0, done}, 32'd0);
      check("clr_trap", {31'b0, trap}, 32'd0);
      trk_rd = '0; trk_rd2 = '0;
      mfc_block = 0;
      repeat (3) @(posedge Clk);
      issue(0, 2'd2, 0, 8'h20, 32'h0, 32'h0, 1, 0);
      issue(1, 2'd3, 0, 8'h28, 32'hCAFE_F00D, 32'h0BAD_D00D, 1, 0);
      issue(0, 2'd3, 0, 8'h28, 32'h0, 32'h0, 0, 0);
      issue(0, 2'd1, 1, 8'h2A, 32'h0, 32'h0, 0, 0);
      issue(0, 2'd0, 0, 8'h29, 32'h0, 32'h0, 0, 0);

`ifdef MEM_TIMEOUT_EN
      issue(0, 2'd2, 0, 8'h40, 32'h0, 32'h0, 0, 1);
`endif

      // Random mix of sizes, offsets, directions and MFC delays
      for (int n = 0; n < 24; n++) begin
         logic [1:0] rsz;
         logic [7:0] ra;
         rsz = 2'($urandom_range(0, 3));
         ra  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0) ra = ra & ~8'((1 << rsz) - 1);
         issue(1'($urandom_range(0, 1)), rsz, 1'($urandom_range(0, 1)), ra,
               $urandom(), $urandom(), int'($urandom_range(0, 2)), 0);
      end

      repeat (3) @(posedge Clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
